div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- EX-stage sequencer that sits directly upstream of the iterative divider and consumes its result.
- Captures DIV/DIVU operands, drives the divider start/annul handshake, and holds operands stable for the whole operation.
- Stalls the pipeline until the divider reports ready, then issues a one-cycle HI/LO write of the result.
- Also handles flush (annul), divider-timeout detection and a busy-cycle counter.

Parameters:
- TIMEOUT, 40: maximum BUSY cycles before err_timeout_o sets.
- CNT_W, 16: width of the busy-cycle performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- div_req_i  in  1  EX instruction is DIV or DIVU and valid.
- signed_i  in  1  1 = DIV, 0 = DIVU.
- rs_data_i  in  32  dividend.
- rt_data_i  in  32  divisor.
- flush_i  in  1  pipeline flush; cancels the current division.
- div_result_i  in  64  from divider: [63:32] remainder, [31:0] quotient.
- div_ready_i  in  1  from divider: result valid.
- div_opdata1_o  out  32  to divider: registered dividend.
- div_opdata2_o  out  32  to divider: registered divisor.
- div_signed_o  out  1  to divider: registered signed flag.
- div_start_o  out  1  to divider: start, held high for the whole operation.
- div_annul_o  out  1  to divider: cancel pulse.
- stallreq_o  out  1  stall request to the pipeline controller.
- hi_we_o  out  1  HI write enable, one-cycle pulse.
- lo_we_o  out  1  LO write enable, one-cycle pulse.
- hi_o  out  32  remainder.
- lo_o  out  32  quotient.
- busy_cnt_o  out  CNT_W  total BUSY cycles since reset; saturates at all-ones.
- err_timeout_o  out  1  sticky; set when a BUSY episode exceeds TIMEOUT cycles.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; every output and internal register cleared to 0. Reset mid-operation aborts immediately, and no HI/LO write occurs.
- States: IDLE, BUSY, DONE. Encoding is free.
- IDLE:
  - stallreq_o = div_req_i & ~flush_i (combinational), so the DIV instruction holds in EX the same cycle.
  - If div_req_i & ~flush_i: register rs/rt/signed into div_opdata1/2_o and div_signed_o, set div_start_o=1, clear the episode timer, go to BUSY.
  - Otherwise: div_start_o=0.
- BUSY:
  - Operands are frozen; the divider re-reads them at its sign-correction step.
  - div_start_o=1, stallreq_o=1, busy_cnt_o increments each cycle.
  - flush_i=1 has priority over div_ready_i: div_start_o<=0, div_annul_o pulses 1 for exactly one cycle, go to IDLE, no write.
  - Else if div_ready_i=1: register hi_o<=div_result_i[63:32], lo_o<=div_result_i[31:0], go to DONE.
  - Episode timer reaching TIMEOUT sets err_timeout_o. The state is unchanged; stall persists until ready or flush.
- DONE (exactly one cycle):
  - hi_we_o=lo_we_o=1; stallreq_o=0 so the pipeline advances.
  - div_start_o=0, which returns the divider to idle. Go to IDLE.
  - A new div_req_i is not accepted in DONE; it is accepted in the following IDLE cycle, with stall covering the gap.
  - flush_i in DONE: the write still occurs, because the instruction has committed.
- Latency is not fixed. The controller waits on div_ready_i only. Nominal divider latency is about 35 cycles after start; divide-by-zero returns in about 3 cycles with a result of 0.
- div_annul_o is 0 in every state except the flush-from-BUSY pulse.
- hi_o/lo_o hold their last values between operations.
- busy_cnt_o saturates and never wraps.

Test Plan:
- DIVU rs=100, rt=7 → stall held until ready; DONE pulse with lo_o=14, hi_o=2; hi_we_o/lo_we_o high for exactly 1 cycle; stallreq_o drops that cycle.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; div_opdata1/2_o constant throughout BUSY.
- DIVU rt=0 → completes in a few cycles; hi_o=lo_o=0; write pulse occurs; err_timeout_o stays 0.
- flush_i asserted 10 cycles into BUSY → div_annul_o one-cycle pulse, div_start_o=0, no hi_we_o/lo_we_o, back to IDLE; a new DIVU 9/3 then yields lo=3, hi=0.
- Back-to-back: DIVU 50/5 then DIVU 17/4 → two separate write pulses (lo=10,hi=0; lo=4,hi=1); second start only after one IDLE cycle.
- rst driven low mid-BUSY with ready stubbed low for 50 cycles → all outputs 0 immediately; in a separate run without reset, err_timeout_o sets at cycle 40 and stays set.

Source files
------------

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - EX-stage sequencer for the iterative divider: operand capture, start/annul, stall and HI/LO write
module div_ctrl #(
   parameter int TIMEOUT = 40,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              div_req_i,
   input  logic              signed_i,
   input  logic [31:0]       rs_data_i,
   input  logic [31:0]       rt_data_i,
   input  logic              flush_i,
   input  logic [63:0]       div_result_i,
   input  logic              div_ready_i,
   output logic [31:0]       div_opdata1_o,
   output logic [31:0]       div_opdata2_o,
   output logic              div_signed_o,
   output logic              div_start_o,
   output logic              div_annul_o,
   output logic              stallreq_o,
   output logic              hi_we_o,
   output logic              lo_we_o,
   output logic [31:0]       hi_o,
   output logic [31:0]       lo_o,
   output logic [CNT_W-1:0]  busy_cnt_o,
   output logic              err_timeout_o
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t             state;
   state_t             state_nxt;
   logic               accept;
   logic [TMR_W-1:0]   timer;

   assign accept = (state == S_IDLE) && div_req_i && !flush_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Flush wins over ready: an annulled instruction never writes HI/LO.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (accept) state_nxt = S_BUSY;
         S_BUSY: begin
            if (flush_i) begin
               state_nxt = S_IDLE;
            end else if (div_ready_i) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      stallreq_o = 1'b0;
      hi_we_o    = 1'b0;
      lo_we_o    = 1'b0;
      unique case (state)
         S_IDLE: stallreq_o = div_req_i && !flush_i;
         S_BUSY: stallreq_o = 1'b1;
         S_DONE: begin
            hi_we_o = 1'b1;
            lo_we_o = 1'b1;
         end
         default: stallreq_o = 1'b0;
      endcase
   end

   // Operands stay frozen through BUSY; the divider re-reads them for sign correction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_opdata1_o <= '0;
         div_opdata2_o <= '0;
         div_signed_o  <= 1'b0;
         div_start_o   <= 1'b0;
         div_annul_o   <= 1'b0;
         hi_o          <= '0;
         lo_o          <= '0;
         busy_cnt_o    <= '0;
         err_timeout_o <= 1'b0;
         timer         <= '0;
      end else begin
         div_annul_o <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  div_opdata1_o <= rs_data_i;
                  div_opdata2_o <= rt_data_i;
                  div_signed_o  <= signed_i;
                  div_start_o   <= 1'b1;
                  timer         <= '0;
               end else begin
                  div_start_o <= 1'b0;
               end
            end
            S_BUSY: begin
               if (busy_cnt_o != '1) begin
                  busy_cnt_o <= busy_cnt_o + 1'b1;
               end
               if (timer != TMR_W'(TIMEOUT)) begin
                  timer <= timer + 1'b1;
               end
               if (timer == TMR_W'(TIMEOUT - 1)) begin
                  err_timeout_o <= 1'b1;
               end
               if (flush_i) begin
                  div_start_o <= 1'b0;
                  div_annul_o <= 1'b1;
               end else if (div_ready_i) begin
                  hi_o        <= div_result_i[63:32];
                  lo_o        <= div_result_i[31:0];
                  div_start_o <= 1'b0;
               end
            end
            S_DONE: begin
               div_start_o <= 1'b0;
            end
            default: begin
               div_start_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed bench for div_ctrl with a stubbed divider
module tb_div_ctrl;

   localparam int TIMEOUT = 40;
   localparam int CNT_W   = 7;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              div_req_i;
   logic              signed_i;
   logic [31:0]       rs_data_i;
   logic [31:0]       rt_data_i;
   logic              flush_i;
   logic [63:0]       div_result_i;
   logic              div_ready_i;
   logic [31:0]       div_opdata1_o;
   logic [31:0]       div_opdata2_o;
   logic              div_signed_o;
   logic              div_start_o;
   logic              div_annul_o;
   logic              stallreq_o;
   logic              hi_we_o;
   logic              lo_we_o;
   logic [31:0]       hi_o;
   logic [31:0]       lo_o;
   logic [CNT_W-1:0]  busy_cnt_o;
   logic              err_timeout_o;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          exp_busy = 0;
   logic        exp_err  = 1'b0;
   logic [31:0] exp_hi   = '0;
   logic [31:0] exp_lo   = '0;
   logic [31:0] cur_a;
   logic [31:0] cur_b;
   logic        cur_s;

   div_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .div_req_i     (div_req_i),
      .signed_i      (signed_i),
      .rs_data_i     (rs_data_i),
      .rt_data_i     (rt_data_i),
      .flush_i       (flush_i),
      .div_result_i  (div_result_i),
      .div_ready_i   (div_ready_i),
      .div_opdata1_o (div_opdata1_o),
      .div_opdata2_o (div_opdata2_o),
      .div_signed_o  (div_signed_o),
      .div_start_o   (div_start_o),
      .div_annul_o   (div_annul_o),
      .stallreq_o    (stallreq_o),
      .hi_we_o       (hi_we_o),
      .lo_we_o       (lo_we_o),
      .hi_o          (hi_o),
      .lo_o          (lo_o),
      .busy_cnt_o    (busy_cnt_o),
      .err_timeout_o (err_timeout_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add_busy(input int n);
      exp_busy = (exp_busy + n > CNT_MAX) ? CNT_MAX : exp_busy + n;
   endtask

   // Called in an IDLE cycle; returns in the first BUSY cycle with the inputs scrambled.
   task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      div_req_i = 1'b1;
      signed_i  = sgn;
      rs_data_i = a;
      rt_data_i = b;
      #1;
      check("idle_stall", 128'(stallreq_o), 128'(1'b1));
      check("idle_start", 128'(div_start_o), 128'(1'b0));
      tick();
      div_req_i = 1'b0;
      signed_i  = ~sgn;
      rs_data_i = $urandom;
      rt_data_i = $urandom;
      cur_a = a;
      cur_b = b;
      cur_s = sgn;
      check("accept_start", 128'(div_start_o), 128'(1'b1));
      check("accept_ops", 128'({div_opdata1_o, div_opdata2_o, div_signed_o}), 128'({a, b, sgn}));
   endtask

   // Divider answers in the lat-th BUSY cycle; returns in the DONE cycle.
   task automatic finish_op(input int lat, input logic [31:0] h, input logic [31:0] l);
      for (int k = 1; k < lat; k++) begin
         check("busy_hold", 128'({stallreq_o, div_start_o, div_annul_o, hi_we_o, lo_we_o,
                                  div_opdata1_o, div_opdata2_o, div_signed_o}),
               128'({5'b11000, cur_a, cur_b, cur_s}));
         tick();
      end
      div_ready_i  = 1'b1;
      div_result_i = {h, l};
      tick();
      div_ready_i  = 1'b0;
      div_result_i = {$urandom, $urandom};
      add_busy(lat);
      exp_hi = h;
      exp_lo = l;
      check("done_ctl", 128'({hi_we_o, lo_we_o, stallreq_o, div_start_o, div_annul_o}), 128'(5'b11000));
      check("done_hi", 128'(hi_o), 128'(h));
      check("done_lo", 128'(lo_o), 128'(l));
   endtask

   task automatic after_done();
      tick();
      check("idle_we", 128'({hi_we_o, lo_we_o, stallreq_o, div_start_o}), 128'(4'b0000));
      check("hold_hilo", 128'({hi_o, lo_o}), 128'({exp_hi, exp_lo}));
      check("busy_cnt", 128'(busy_cnt_o), 128'(exp_busy));
      check("err_timeout", 128'(err_timeout_o), 128'(exp_err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b0;
      div_req_i    = 1'b0;
      signed_i     = 1'b0;
      rs_data_i    = '0;
      rt_data_i    = '0;
      flush_i      = 1'b0;
      div_result_i = '0;
      div_ready_i  = 1'b0;
      tick();
      tick();
      check("rst_ctl", 128'({div_start_o, div_annul_o, stallreq_o, hi_we_o, lo_we_o, div_signed_o, err_timeout_o}),
            128'(7'b0));
      check("rst_data", 128'({div_opdata1_o, div_opdata2_o, hi_o, lo_o}), 128'(0));
      check("rst_cnt", 128'(busy_cnt_o), 128'(0));
      rst = 1'b1;
      tick();

      issue(1'b0, 32'd100, 32'd7);
      finish_op(35, 32'd2, 32'd14);
      after_done();

      issue(1'b1, 32'hFFFF_FFF9, 32'd2);
      finish_op(35, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      after_done();

      issue(1'b0, 32'd1234, 32'd0);
      finish_op(3, 32'd0, 32'd0);
      after_done();

      div_req_i = 1'b1;
      flush_i   = 1'b1;
      #1;
      check("flush_idle_stall", 128'(stallreq_o), 128'(1'b0));
      tick();
      div_req_i = 1'b0;
      flush_i   = 1'b0;
      check("flush_idle_start", 128'(div_start_o), 128'(1'b0));

      issue(1'b0, 32'd1000, 32'd3);
      for (int k = 1; k < 10; k++) tick();
      flush_i = 1'b1;
      #1;
      check("flush_busy_stall", 128'({stallreq_o, div_annul_o}), 128'(2'b10));
      tick();
      flush_i = 1'b0;
      add_busy(10);
      check("annul_pulse", 128'({div_annul_o, div_start_o, hi_we_o, lo_we_o, stallreq_o}), 128'(5'b10000));
      tick();
      check("annul_clear", 128'({div_annul_o, div_start_o, hi_we_o, lo_we_o}), 128'(4'b0000));
      check("flush_cnt", 128'(busy_cnt_o), 128'(exp_busy));
      issue(1'b0, 32'd9, 32'd3);
      finish_op(5, 32'd0, 32'd3);
      after_done();

      issue(1'b0, 32'd50, 32'd5);
      finish_op(35, 32'd0, 32'd10);
      div_req_i = 1'b1;
      signed_i  = 1'b0;
      rs_data_i = 32'd17;
      rt_data_i = 32'd4;
      #1;
      check("b2b_done_nostall", 128'({stallreq_o, hi_we_o}), 128'(2'b01));
      tick();
      check("b2b_gap", 128'({div_start_o, hi_we_o, lo_we_o, stallreq_o}), 128'(4'b0001));
      issue(1'b0, 32'd17, 32'd4);
      finish_op(35, 32'd1, 32'd4);
      after_done();
      check("cnt_saturated", 128'(busy_cnt_o), 128'(CNT_MAX));

      issue(1'b0, 32'd123, 32'd4);
      for (int k = 0; k < 20; k++) tick();
      #2;
      rst = 1'b0;
      #1;
      check("midrst_ctl", 128'({div_start_o, div_annul_o, stallreq_o, hi_we_o, lo_we_o, div_signed_o, err_timeout_o}),
            128'(7'b0));
      check("midrst_data", 128'({div_opdata1_o, div_opdata2_o, hi_o, lo_o}), 128'(0));
      check("midrst_cnt", 128'(busy_cnt_o), 128'(0));
      tick();
      check("midrst_nowrite", 128'({hi_we_o, lo_we_o, hi_o, lo_o}), 128'(0));
      rst      = 1'b1;
      exp_busy = 0;
      exp_hi   = '0;
      exp_lo   = '0;
      tick();

      issue(1'b0, 32'd77, 32'd11);
      for (int k = 1; k <= TIMEOUT; k++) begin
         check("tmo_not_yet", 128'(err_timeout_o), 128'(1'b0));
         tick();
      end
      check("tmo_set", 128'(err_timeout_o), 128'(1'b1));
      exp_err = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("tmo_sticky", 128'({err_timeout_o, stallreq_o, div_start_o}), 128'(3'b111));
      end
      add_busy(TIMEOUT + 5);
      finish_op(1, 32'd0, 32'd7);
      after_done();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
